// File: rtl/img_uart_streamer_pkg.sv
// Shared types and helpers for the image-to-UART streamer.
//   mode_e  : output format selector (gray, gray x3, raw RGB, inverted gray)
//   state_e : streamer FSM states
//   gray_fn : luma approximation (R + 2G + B) >> 2
package img_stream_pkg;

  typedef enum logic [1:0] {
    MODE_GRAY  = 2'd0,
    MODE_GRAY3 = 2'd1,
    MODE_RGB   = 2'd2,
    MODE_INV   = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } state_e;

  // Widest channel the gray helper supports.
  localparam int unsigned CH_MAX = 32;

  // Callers zero-extend their CH_BITS-wide channels to CH_MAX and keep the
  // low CH_BITS of the result. The sum carries two extra bits, so the
  // result is exact for any channel width up to CH_MAX.
  function automatic logic [CH_MAX-1:0] gray_fn(input logic [CH_MAX-1:0] r,
                                                input logic [CH_MAX-1:0] g,
                                                input logic [CH_MAX-1:0] b);
    logic [CH_MAX+1:0] sum;
    sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return sum[CH_MAX+1:2];
  endfunction

endpackage

// File: rtl/img_uart_streamer_if.sv
// Memory-read and UART-write signal bundle of the streamer.
//   mem_addr  : pixel RAM read address (streamer -> RAM)
//   mem_rdata : pixel RAM data, one cycle after mem_addr (RAM -> streamer)
//   tx_full   : UART TX FIFO full (UART -> streamer)
//   wr_uart   : byte write strobe (streamer -> UART)
//   w_data    : byte to transmit (streamer -> UART)
// master = streamer side, slave = RAM/UART side.
interface img_uart_streamer_if #(
  parameter int ADDR_BITS = 13,
  parameter int PIX_WIDTH = 24
);
  localparam int CH_BITS = PIX_WIDTH / 3;

  logic [ADDR_BITS-1:0] mem_addr;
  logic [PIX_WIDTH-1:0] mem_rdata;
  logic                 tx_full;
  logic                 wr_uart;
  logic [CH_BITS-1:0]   w_data;

  modport master (
    output mem_addr,
    input  mem_rdata,
    input  tx_full,
    output wr_uart,
    output w_data
  );

  modport slave (
    input  mem_addr,
    output mem_rdata,
    output tx_full,
    input  wr_uart,
    input  w_data
  );
endinterface

// File: rtl/img_uart_streamer_pix_formatter.sv
// Combinational pixel-to-byte formatter.
//   pix       : captured pixel, R in the MSBs
//   mode      : output format
//   idx       : byte index within the pixel (0..2)
//   w_data    : selected output byte
//   last_byte : idx is the final byte of the pixel for this mode
module pix_formatter
  import img_stream_pkg::*;
#(
  parameter int PIX_WIDTH = 24,
  parameter int CH_BITS   = PIX_WIDTH / 3
) (
  input  logic [PIX_WIDTH-1:0] pix,
  input  mode_e                mode,
  input  logic [1:0]           idx,
  output logic [CH_BITS-1:0]   w_data,
  output logic                 last_byte
);

  logic [CH_BITS-1:0] r, g, b, gray;
  logic [CH_MAX-1:0]  gray_wide;
  logic               unused_gray_hi;

  always_comb begin
    r         = pix[PIX_WIDTH-1 -: CH_BITS];
    g         = pix[2*CH_BITS-1 -: CH_BITS];
    b         = pix[CH_BITS-1:0];
    gray_wide = gray_fn(CH_MAX'(r), CH_MAX'(g), CH_MAX'(b));
    gray      = gray_wide[CH_BITS-1:0];
  end

  // Upper bits are always zero: the gray result fits in CH_BITS.
  assign unused_gray_hi = ^gray_wide[CH_MAX-1:CH_BITS];

  always_comb begin
    w_data    = gray;
    last_byte = 1'b1;
    unique case (mode)
      MODE_GRAY: begin
        w_data    = gray;
        last_byte = 1'b1;
      end
      MODE_GRAY3: begin
        w_data    = gray;
        last_byte = (idx == 2'd2);
      end
      MODE_RGB: begin
        last_byte = (idx == 2'd2);
        if (idx == 2'd0)      w_data = r;
        else if (idx == 2'd1) w_data = g;
        else                  w_data = b;
      end
      MODE_INV: begin
        w_data    = ~gray;
        last_byte = 1'b1;
      end
      default: begin
        w_data    = gray;
        last_byte = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/img_uart_streamer.sv
// Frame streamer: reads pixel_count pixels from the pixel RAM starting at
// address 0 and sends them to the UART as bytes in the selected format,
// honouring TX FIFO backpressure. Optional loop mode restarts at address 0.
//   clk, reset  : clock, synchronous active-high reset
//   start       : one-cycle frame request (IDLE only)
//   mode        : output format, latched at start
//   loop        : repeat the frame forever, latched at start
//   pixel_count : frame length, clamped to 2^ADDR_BITS, latched at start
//   bus         : RAM read / UART write bundle (master side)
//   busy        : FSM not in IDLE
//   done        : one-cycle pulse at frame completion
module img_uart_streamer
  import img_stream_pkg::*;
#(
  parameter int ADDR_BITS = 13,
  parameter int PIX_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 loop,
  input  logic [ADDR_BITS:0]   pixel_count,
  img_uart_streamer_if.master  bus,
  output logic                 busy,
  output logic                 done
);

  localparam int CH_BITS = PIX_WIDTH / 3;

  state_e               state_q, state_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [ADDR_BITS-1:0] last_q, last_d;
  mode_e                mode_q, mode_d;
  logic                 loop_q, loop_d;
  logic [PIX_WIDTH-1:0] pix_q, pix_d;
  logic [1:0]           idx_q, idx_d;
  logic                 wr_uart_c;
  logic [CH_BITS-1:0]   fmt_data;
  logic                 fmt_last;

  pix_formatter #(
    .PIX_WIDTH (PIX_WIDTH),
    .CH_BITS   (CH_BITS)
  ) u_fmt (
    .pix       (pix_q),
    .mode      (mode_q),
    .idx       (idx_q),
    .w_data    (fmt_data),
    .last_byte (fmt_last)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    mode_d    = mode_q;
    loop_d    = loop_q;
    pix_d     = pix_q;
    idx_d     = idx_q;
    wr_uart_c = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pixel_count == '0) begin
            state_d = ST_DONE;
          end else begin
            mode_d  = mode_e'(mode);
            loop_d  = loop;
            // Any count with the top bit set is at least 2^ADDR_BITS, so
            // the clamped last address is all-ones.
            last_d  = pixel_count[ADDR_BITS] ? '1
                                             : pixel_count[ADDR_BITS-1:0] - ADDR_BITS'(1);
            addr_d  = '0;
            state_d = ST_READ;
          end
        end
      end
      ST_READ: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        pix_d   = bus.mem_rdata;
        idx_d   = '0;
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (!bus.tx_full) begin
          wr_uart_c = 1'b1;
          if (fmt_last) begin
            if (addr_q == last_q) begin
              if (loop_q) begin
                addr_d  = '0;
                state_d = ST_READ;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              addr_d  = addr_q + ADDR_BITS'(1);
              state_d = ST_READ;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      last_q  <= '0;
      mode_q  <= MODE_GRAY;
      loop_q  <= 1'b0;
      pix_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      mode_q  <= mode_d;
      loop_q  <= loop_d;
      pix_q   <= pix_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.mem_addr = addr_q;
  assign bus.wr_uart  = wr_uart_c;
  assign bus.w_data   = (state_q == ST_SEND) ? fmt_data : '0;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_img_uart_streamer.sv
// Self-checking bench for img_uart_streamer: table of single-pixel frames,
// hand-written corner sequences and randomized frames against a byte-stream
// reference model computed from the format rules.
module tb_img_uart_streamer;

  localparam int AB = 13;
  localparam int PW = 24;
  localparam int NPIX = 1 << AB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, start, loop_i, busy, done;
  logic [1:0]    mode;
  logic [AB:0]   pixel_count;

  img_uart_streamer_if #(.ADDR_BITS(AB), .PIX_WIDTH(PW)) bus ();

  img_uart_streamer #(.ADDR_BITS(AB), .PIX_WIDTH(PW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .loop        (loop_i),
    .pixel_count (pixel_count),
    .bus         (bus.master),
    .busy        (busy),
    .done        (done)
  );

  logic [PW-1:0] ram [0:NPIX-1];
  always @(posedge clk) bus.mem_rdata <= ram[bus.mem_addr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int nbytes(input int m);
    return (m == 1 || m == 2) ? 3 : 1;
  endfunction

  // Reference formatting straight from the channel arithmetic.
  function automatic logic [7:0] fmt(input int m, input logic [23:0] p, input int j);
    int r, g, b, gy;
    r  = int'(p[23:16]);
    g  = int'(p[15:8]);
    b  = int'(p[7:0]);
    gy = (r + 2 * g + b) / 4;
    case (m)
      0, 1: return 8'(gy);
      2:    return 8'(j == 0 ? r : (j == 1 ? g : b));
      default: return 8'(255 - gy);
    endcase
  endfunction

  logic [7:0] got_b[$];
  int         got_k[$];
  int         got_a[$];
  logic [7:0] stall_w[$];
  int done_k, done_n, wr_full_n, busy_bad, addr_nz;

  // Starts a frame and observes it for up to max_k cycles after the start
  // edge. Cycle k is sampled just after the falling edge following edge N+k.
  task automatic run(input int m, input int cnt, input bit lp, input int stall_pct,
                     input int s0, input int slen, input int inj_k, input int max_k);
    bit tx;
    got_b.delete(); got_k.delete(); got_a.delete(); stall_w.delete();
    done_k = -1; done_n = 0; wr_full_n = 0; busy_bad = 0; addr_nz = 0;
    @(negedge clk);
    mode = 2'(m); loop_i = lp; pixel_count = (AB + 1)'(cnt); start = 1'b1;
    bus.tx_full = 1'b0;
    for (int k = 1; k <= max_k; k++) begin
      @(negedge clk);
      start = (k == inj_k);
      if (k == inj_k) begin
        mode = 2'(~m); loop_i = 1'b1; pixel_count = (AB + 1)'(1);
      end
      tx = (k >= s0 && k < s0 + slen) || (int'($urandom_range(0, 99)) < stall_pct);
      bus.tx_full = tx;
      #1;
      if (bus.wr_uart) begin
        got_b.push_back(bus.w_data);
        got_k.push_back(k);
        got_a.push_back(int'(bus.mem_addr));
      end
      if (bus.tx_full && bus.wr_uart) wr_full_n++;
      if (k >= s0 && k < s0 + slen) stall_w.push_back(bus.w_data);
      if (bus.mem_addr != '0) addr_nz++;
      if (done) begin
        done_n++;
        if (done_k < 0) done_k = k;
      end
      if (!lp && done_k >= 0 && k == done_k + 1) begin
        check("busy_fall", int'(busy), 0);
        break;
      end else if (!busy) begin
        busy_bad++;
      end
    end
    bus.tx_full = 1'b0;
    start = 1'b0;
  endtask

  task automatic verify(input string tag, input int m, input int cnt, input bit lp,
                        input bit timing);
    int nb, bad_b, bad_a, bad_k, pi, a;
    nb = nbytes(m); bad_b = 0; bad_a = 0; bad_k = 0;
    if (!lp) begin
      check({tag, " nwr"}, got_b.size(), cnt * nb);
      check({tag, " done_n"}, done_n, 1);
    end else begin
      check({tag, " no_done"}, done_n, 0);
    end
    for (int i = 0; i < got_b.size(); i++) begin
      pi = i / nb;
      a  = lp ? pi % cnt : pi;
      if (a >= NPIX || got_b[i] !== fmt(m, ram[a], i % nb)) bad_b++;
      if (got_a[i] != a) bad_a++;
      if (timing && got_k[i] != 3 + (2 + nb) * pi + i % nb) bad_k++;
    end
    check({tag, " byte_errs"}, bad_b, 0);
    check({tag, " addr_errs"}, bad_a, 0);
    if (timing) begin
      check({tag, " cycle_errs"}, bad_k, 0);
      if (!lp && got_k.size() > 0) check({tag, " done_cyc"}, done_k, got_k[$] + 1);
    end
    check({tag, " wr_while_full"}, wr_full_n, 0);
    check({tag, " busy_gap"}, busy_bad, 0);
  endtask

  typedef struct {
    int          m;
    logic [23:0] pix;
    int          nb;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[8];
  int   bad, found, rm, rc;

  initial begin
    tbl[0] = '{2, 24'hA1B2C3, 3, 24'hA1B2C3};
    tbl[1] = '{1, 24'hA1B2C3, 3, 24'hB2B2B2};
    tbl[2] = '{3, 24'hA1B2C3, 1, 24'h4D0000};
    tbl[3] = '{0, 24'hFFFFFF, 1, 24'hFF0000};
    tbl[4] = '{3, 24'h000000, 1, 24'hFF0000};
    tbl[5] = '{2, 24'h102030, 3, 24'h102030};
    tbl[6] = '{0, 24'h000000, 1, 24'h000000};
    tbl[7] = '{1, 24'hFFFFFF, 3, 24'hFFFFFF};

    reset = 1'b1; start = 1'b0; mode = '0; loop_i = 1'b0; pixel_count = '0;
    bus.tx_full = 1'b0;
    for (int i = 0; i < NPIX; i++) ram[i] = 24'($urandom);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst wr_uart", int'(bus.wr_uart), 0);
    check("rst w_data", int'(bus.w_data), 0);
    check("rst mem_addr", int'(bus.mem_addr), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;

    // Three-pixel gray frame with exact byte cycles
    ram[0] = 24'h102030; ram[1] = 24'hFFFFFF; ram[2] = 24'h000000;
    run(0, 3, 0, 0, 0, 0, 0, 30);
    check("tp b0", got_b.size() > 0 ? int'(got_b[0]) : -1, 'h20);
    check("tp b1", got_b.size() > 1 ? int'(got_b[1]) : -1, 'hFF);
    check("tp b2", got_b.size() > 2 ? int'(got_b[2]) : -1, 'h00);
    check("tp k0", got_k.size() > 0 ? got_k[0] : -1, 3);
    check("tp k1", got_k.size() > 1 ? got_k[1] : -1, 6);
    check("tp k2", got_k.size() > 2 ? got_k[2] : -1, 9);
    check("tp done_k", done_k, 10);
    verify("tp", 0, 3, 0, 1);

    // Single-pixel format table
    foreach (tbl[t]) begin
      ram[0] = tbl[t].pix;
      run(tbl[t].m, 1, 0, 0, 0, 0, 0, 20);
      check($sformatf("tbl%0d nwr", t), got_b.size(), tbl[t].nb);
      bad = 0;
      for (int j = 0; j < tbl[t].nb && j < got_b.size(); j++) begin
        if (got_b[j] !== tbl[t].exp[23 - 8 * j -: 8]) bad++;
        if (got_k[j] != 3 + j) bad++;
      end
      check($sformatf("tbl%0d bytes", t), bad, 0);
      check($sformatf("tbl%0d done_k", t), done_k, 3 + tbl[t].nb);
    end

    // Backpressure on the second byte of a gray x3 pixel
    ram[0] = 24'hA1B2C3;
    run(1, 1, 0, 0, 4, 5, 0, 30);
    check("stall nwr", got_b.size(), 3);
    check("stall k1", got_k.size() > 1 ? got_k[1] : -1, 9);
    check("stall k2", got_k.size() > 2 ? got_k[2] : -1, 10);
    check("stall wr_while_full", wr_full_n, 0);
    bad = 0;
    foreach (stall_w[i]) if (stall_w[i] !== 8'hB2) bad++;
    check("stall w_data_hold", bad, 0);
    check("stall done_k", done_k, 11);

    // Start pulse with other settings while busy is ignored
    for (int i = 0; i < 4; i++) ram[i] = 24'($urandom);
    run(0, 4, 0, 0, 0, 0, 5, 40);
    verify("inj", 0, 4, 0, 1);

    // Loop mode, then reset in the middle of a SEND
    ram[0] = 24'h0000FF; ram[1] = 24'hFF0000;
    run(0, 2, 1, 0, 0, 0, 0, 40);
    check("loop nwr", got_b.size(), 13);
    verify("loop", 0, 2, 1, 1);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (bus.wr_uart) begin found = 1; break; end
    end
    check("loop send_seen", found, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort wr_uart", int'(bus.wr_uart), 0);
    check("abort w_data", int'(bus.w_data), 0);
    check("abort mem_addr", int'(bus.mem_addr), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (done || busy || bus.wr_uart) bad++;
    end
    check("abort quiet", bad, 0);

    // Zero-length frame
    run(2, 0, 0, 0, 0, 0, 0, 10);
    check("zero done_k", done_k, 1);
    check("zero nwr", got_b.size(), 0);
    check("zero addr", addr_nz, 0);
    check("zero done_n", done_n, 1);

    // Fresh frame after abort
    ram[0] = 24'h123456; ram[1] = 24'hABCDEF;
    run(2, 2, 0, 0, 0, 0, 0, 30);
    verify("fresh", 2, 2, 0, 1);

    // Randomized frames with random backpressure
    for (int f = 0; f < 6; f++) begin
      rm = int'($urandom_range(0, 3));
      rc = int'($urandom_range(1, 12));
      for (int i = 0; i < rc; i++) ram[i] = 24'($urandom);
      run(rm, rc, 0, 30, 0, 0, 0, 400);
      verify($sformatf("rnd%0d", f), rm, rc, 0, 0);
    end

    // Full address space, then an over-range count that must clamp
    run(0, NPIX, 0, 0, 0, 0, 0, NPIX * 3 + 10);
    verify("full", 0, NPIX, 0, 1);
    check("full last_addr", got_a.size() > 0 ? got_a[$] : -1, NPIX - 1);
    run(3, 2 * NPIX - 1, 0, 0, 0, 0, 0, NPIX * 3 + 10);
    verify("clamp", 3, NPIX, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/img_uart_streamer.md
# img_uart_streamer

Parametrised frame streamer between the 24-bit pixel RAM (`meminferida`, 1-cycle read latency) and the UART transmitter. On `start`, it reads `pixel_count` pixels from address 0 upward and formats each pixel into UART bytes according to `mode`. Each byte is written only when the TX FIFO has room. It replaces the free-running address counter and always-asserted `wr_uart` of the first-generation sequencer with proper start/busy/done control, flow control, selectable output formats and an optional loop mode.

## Interface
- `ADDR_BITS`, 13, pixel RAM address width
- `PIX_WIDTH`, 24, pixel width; three equal channels, R in the MSBs
- `CH_BITS`, derived `PIX_WIDTH/3` (8), channel and UART byte width
- `clk` in 1: single clock
- `reset` in 1: synchronous, active-high
- `start` in 1: one-cycle request; sampled only in IDLE
- `mode` in 2: 0 = gray (1 byte/pixel), 1 = gray ×3 (R,G,B all gray), 2 = raw RGB (R,G,B), 3 = inverted gray (1 byte); latched at start
- `loop` in 1: latched at start; 1 = wrap to address 0 after the last pixel and never finish
- `pixel_count` in ADDR_BITS+1: number of pixels in the frame; latched at start
- `mem_addr` out ADDR_BITS: RAM read address (registered)
- `mem_rdata` in PIX_WIDTH: RAM data, valid one cycle after `mem_addr`
- `tx_full` in 1: UART TX FIFO full
- `wr_uart` out 1: write strobe, one byte per asserted cycle
- `w_data` out CH_BITS: byte to UART
- `busy` out 1: high in any state other than IDLE
- `done` out 1: one-cycle pulse when the frame completes

## Operation
- Gray: `(R + 2G + B) >> 2`, with the sum computed at CH_BITS+2 bits (no overflow). The result always fits in CH_BITS. Inverted gray = `~gray`.
- States:
  - IDLE:
    - `start` with `pixel_count == 0` -> DONE.
    - `start` with nonzero count -> latch `mode`, `loop`, and `last = pixel_count-1`; set `addr = 0`; go to READ.
    - `pixel_count` above 2^ADDR_BITS is clamped to 2^ADDR_BITS.
  - READ: `mem_addr` = addr is presented; go to CAPTURE.
  - CAPTURE: register `mem_rdata` into `pix`; `idx = 0`; go to SEND.
  - SEND:
    - `wr_uart = !tx_full`, and `w_data` = byte `idx` of the formatted pixel.
    - On a write to a pixel's final byte (idx 0 in modes 0/3, idx 2 in modes 1/2):
      - `addr == last` and `loop == 0` -> DONE.
      - `addr == last` and `loop == 1` -> `addr = 0`, go to READ.
      - otherwise `addr + 1`, go to READ.
    - On a write to any other byte, `idx + 1`.
    - When `tx_full` is high, hold the state, `idx` and `w_data`; `wr_uart` stays 0.
  - DONE: `done = 1` for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored; a running loop ends only via `reset`.
- `pix` is frozen for the whole SEND phase. RAM contents changing mid-pixel do not affect the bytes being sent.

## Timing
- Reset values, effective on the clock edge with `reset` high and overriding every other input:
  - state IDLE.
  - `mem_addr`, `wr_uart`, `w_data`, `busy`, `done`, `addr`, `idx`, `pix` all 0.
- Reset mid-frame aborts with no `done` pulse. No `wr_uart` occurs in the cycle after reset.
- `start` at edge N -> `busy` and `mem_addr = 0` from N+1 -> pixel captured at N+2 -> first `wr_uart` in cycle N+3 (if `tx_full` is low).
- Per pixel without backpressure: 2 overhead cycles plus 1 or 3 byte cycles. Modes 0/3 take 3 cycles/pixel; modes 1/2 take 5 cycles/pixel.
- `done` asserts in the cycle after the last byte write, and `busy` falls in the cycle after `done`.
- `wr_uart` is a combinational AND of the registered state with `!tx_full`. This is the only combinational path from an input to an output.

## Structure
- Package `img_stream_pkg`:
  - mode constants (MODE_GRAY, MODE_GRAY3, MODE_RGB, MODE_INV)
  - state encoding
  - a gray function parametrised on CH_BITS
- Sub-module `pix_formatter`: combinational; takes `pix`, `mode` and `idx` and produces `w_data` and `last_byte`. It is unit-testable in isolation.
- The top holds the FSM, the address counter, and the `pix`/`idx` registers.

## Test plan
- `pixel_count = 3`, mode 0, RAM[0..2] = 0x102030, 0xFFFFFF, 0x000000, `tx_full = 0` -> bytes 0x20, 0xFF, 0x00 on cycles N+3, N+6, N+9; `done` at N+10.
- Mode 2, 1 pixel 0xA1B2C3 -> bytes A1, B2, C3 on consecutive cycles. Mode 1, same pixel -> 0xB2 sent three times ((A1+2·B2+C3)>>2 = 0xB2). Mode 3 -> single byte 0x4D.
- Mode 1, `tx_full` held high for 5 cycles at the second byte -> no `wr_uart` during the stall; `w_data` is stable; exactly 3 writes in total, in order.
- `pixel_count = 0` -> `done` at N+1, no `wr_uart`, `mem_addr` stays 0. A `start` while busy changes nothing.
- `loop = 1`, `pixel_count = 2` -> address sequence 0, 1, 0, 1, … with no `done`. `reset` asserted mid-SEND -> all outputs 0 on the next cycle, then a fresh start behaves normally.
- `pixel_count = 2^ADDR_BITS` -> the last address is all-ones, with no wrap and a single `done`.
